// File: rtl/miner_ctrl.sv
// Job sequencer for a nonce-search miner: it loads a job, holds the miner in reset, and opens a scan window.
// Hits that arrive inside the scan window are queued in a small result FIFO for the host to read.
module miner_ctrl #(
   parameter int unsigned CORES       = 1,
   parameter int unsigned WARMUP      = 735,
   parameter logic [31:0] SCAN_CYCLES = 32'hFFFFFFFF,
   parameter int unsigned RST_CYCLES  = 2,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         work_valid,
   output logic         work_ready,
   input  logic [639:0] work_block,
   input  logic [31:0]  work_nonce_start,
   input  logic         abort,
   output logic         miner_reset,
   output logic [639:0] miner_block,
   output logic [31:0]  miner_nonce_start,
   input  logic         miner_nonce_found,
   input  logic [31:0]  miner_nonce_out,
   output logic         result_valid,
   output logic [31:0]  result_nonce,
   input  logic         result_ready,
   output logic         busy,
   output logic         scan_done,
   output logic         overflow
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [31:0]      LOAD_LAST = 32'(RST_CYCLES - 1);
   // Window bounds are 33 bits wide so that WARMUP+SCAN_CYCLES cannot wrap around.
   localparam logic [32:0] WIN_LO   = 33'(WARMUP);
   localparam logic [32:0] WIN_HI   = 33'(WARMUP) + {1'b0, SCAN_CYCLES};
   localparam logic [32:0] WIN_LAST = WIN_HI - 33'd1;

   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

   state_t         state_q, state_d;
   logic [31:0]    cnt_q, cnt_d;
   logic [639:0]   block_q, block_d;
   logic [31:0]    nstart_q, nstart_d;
   logic           overflow_q, overflow_d;
   logic           scan_done_q, scan_done_d;
   logic [31:0]    mem_q [FIFO_DEPTH];
   logic [31:0]    mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [32:0] cnt_ext;
   logic        in_window, push, pop, full, do_push;

   // CORES describes the attached miner only; the cycle counter does not depend on it.
   logic unused_cores;
   assign unused_cores = |CORES;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   assign cnt_ext   = {1'b0, cnt_q};
   assign in_window = (state_q == RUN) && (cnt_ext >= WIN_LO) && (cnt_ext < WIN_HI);
   assign push      = in_window && miner_nonce_found;
   assign pop       = (count_q != '0) && result_ready;
   assign full      = (count_q == DEPTH_CNT);
   assign do_push   = push && (!full || pop);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      block_d     = block_q;
      nstart_d    = nstart_q;
      overflow_d  = overflow_q;
      scan_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (work_valid) begin
               block_d    = work_block;
               nstart_d   = work_nonce_start;
               cnt_d      = '0;
               overflow_d = 1'b0;
               state_d    = LOAD;
            end
         end
         LOAD: begin
            if (abort) begin
               state_d = IDLE;
            end else if (cnt_q == LOAD_LAST) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         RUN: begin
            cnt_d = cnt_q + 32'd1;
            if (abort) begin
               state_d = IDLE;
            end else if (cnt_ext == WIN_LAST) begin
               state_d     = IDLE;
               scan_done_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (push && full && !pop) begin
         overflow_d = 1'b1;
      end
   end

   always_comb begin
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      if (do_push) begin
         mem_d[wr_q] = miner_nonce_out;
         wr_d        = ptr_inc(wr_q);
      end
      if (pop) begin
         rd_d = ptr_inc(rd_q);
      end
      case ({do_push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         block_q     <= '0;
         nstart_q    <= '0;
         overflow_q  <= 1'b0;
         scan_done_q <= 1'b0;
         mem_q       <= '{default: '0};
         wr_q        <= '0;
         rd_q        <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         block_q     <= block_d;
         nstart_q    <= nstart_d;
         overflow_q  <= overflow_d;
         scan_done_q <= scan_done_d;
         mem_q       <= mem_d;
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         count_q     <= count_d;
      end
   end

   assign work_ready        = (state_q == IDLE);
   assign miner_reset       = (state_q != RUN);
   assign busy              = (state_q != IDLE);
   assign miner_block       = block_q;
   assign miner_nonce_start = nstart_q;
   assign result_valid      = (count_q != '0);
   assign result_nonce      = mem_q[rd_q];
   assign scan_done         = scan_done_q;
   assign overflow          = overflow_q;

endmodule

// File: tb/tb_miner_ctrl.sv
// Directed bench for miner_ctrl with a short window: WARMUP=4, SCAN_CYCLES=8, RST_CYCLES=2, FIFO_DEPTH=4.
// Inputs change 1 time unit after each rising edge, and outputs are checked at that same point.
module tb_miner_ctrl;

   logic         clk;
   logic         reset;
   logic         work_valid;
   logic         work_ready;
   logic [639:0] work_block;
   logic [31:0]  work_nonce_start;
   logic         abort;
   logic         miner_reset;
   logic [639:0] miner_block;
   logic [31:0]  miner_nonce_start;
   logic         miner_nonce_found;
   logic [31:0]  miner_nonce_out;
   logic         result_valid;
   logic [31:0]  result_nonce;
   logic         result_ready;
   logic         busy;
   logic         scan_done;
   logic         overflow;

   int n_asserts = 0;
   int n_fails   = 0;
   logic [639:0] blk;

   miner_ctrl #(
      .CORES(1),
      .WARMUP(4),
      .SCAN_CYCLES(32'd8),
      .RST_CYCLES(2),
      .FIFO_DEPTH(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .work_valid(work_valid),
      .work_ready(work_ready),
      .work_block(work_block),
      .work_nonce_start(work_nonce_start),
      .abort(abort),
      .miner_reset(miner_reset),
      .miner_block(miner_block),
      .miner_nonce_start(miner_nonce_start),
      .miner_nonce_found(miner_nonce_found),
      .miner_nonce_out(miner_nonce_out),
      .result_valid(result_valid),
      .result_nonce(result_nonce),
      .result_ready(result_ready),
      .busy(busy),
      .scan_done(scan_done),
      .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_asserts++;
      assert (observed === expected) else begin
         n_fails++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Accepts a job and leaves the bench in the first RUN cycle (counter 0).
   task automatic start_job(input logic [31:0] start);
      work_nonce_start = start;
      work_valid       = 1'b1;
      applyStimulus(1);
      work_valid = 1'b0;
      applyStimulus(2);
   endtask

   initial begin
      reset             = 1'b1;
      work_valid        = 1'b0;
      work_block        = '0;
      work_nonce_start  = '0;
      abort             = 1'b0;
      miner_nonce_found = 1'b0;
      miner_nonce_out   = '0;
      result_ready      = 1'b0;
      blk               = '0;
      blk[31:0]         = 32'hCAFE0001;
      blk[639:608]      = 32'hBEEF0002;

      applyStimulus(2);
      checkOutput("rst_work_ready", work_ready, 1);
      checkOutput("rst_miner_reset", miner_reset, 1);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_result_valid", result_valid, 0);
      checkOutput("rst_overflow", overflow, 0);
      checkOutput("rst_scan_done", scan_done, 0);
      checkOutput("rst_nonce_start", miner_nonce_start, 0);
      reset = 1'b0;

      $display("[TB] single in-window hit and normal completion");
      work_block       = blk;
      work_nonce_start = 32'h100;
      work_valid       = 1'b1;
      applyStimulus(1);
      work_valid = 1'b0;
      checkOutput("load_busy", busy, 1);
      checkOutput("load_work_ready", work_ready, 0);
      checkOutput("load_miner_reset", miner_reset, 1);
      checkOutput("load_nonce_start", miner_nonce_start, 32'h100);
      checkOutput("load_block_lo", miner_block[31:0], 32'hCAFE0001);
      checkOutput("load_block_hi", miner_block[639:608], 32'hBEEF0002);
      applyStimulus(1);
      checkOutput("load2_miner_reset", miner_reset, 1);
      applyStimulus(1);
      checkOutput("run_miner_reset", miner_reset, 0);
      work_valid       = 1'b1;
      work_nonce_start = 32'hDEAD;
      work_block       = '0;
      applyStimulus(1);
      work_valid = 1'b0;
      checkOutput("run_hold_nonce_start", miner_nonce_start, 32'h100);
      checkOutput("run_hold_block_lo", miner_block[31:0], 32'hCAFE0001);
      checkOutput("run_busy", busy, 1);
      applyStimulus(4);
      miner_nonce_found = 1'b1;
      miner_nonce_out   = 32'h105;
      applyStimulus(1);
      miner_nonce_found = 1'b0;
      checkOutput("hit_valid", result_valid, 1);
      checkOutput("hit_nonce", result_nonce, 32'h105);
      applyStimulus(5);
      checkOutput("last_scan_done", scan_done, 0);
      checkOutput("last_busy", busy, 1);
      applyStimulus(1);
      checkOutput("done_scan_done", scan_done, 1);
      checkOutput("done_busy", busy, 0);
      checkOutput("done_work_ready", work_ready, 1);
      checkOutput("done_miner_reset", miner_reset, 1);
      applyStimulus(1);
      checkOutput("done_pulse_end", scan_done, 0);
      checkOutput("done_head", result_nonce, 32'h105);
      result_ready = 1'b1;
      applyStimulus(1);
      result_ready = 1'b0;
      checkOutput("drain1_valid", result_valid, 0);

      $display("[TB] hits outside the window");
      start_job(32'h200);
      applyStimulus(3);
      miner_nonce_found = 1'b1;
      miner_nonce_out   = 32'h303;
      applyStimulus(1);
      miner_nonce_found = 1'b0;
      checkOutput("early_hit_valid", result_valid, 0);
      applyStimulus(7);
      applyStimulus(1);
      checkOutput("job2_scan_done", scan_done, 1);
      miner_nonce_found = 1'b1;
      miner_nonce_out   = 32'h30C;
      applyStimulus(1);
      miner_nonce_found = 1'b0;
      checkOutput("late_hit_valid", result_valid, 0);
      checkOutput("late_hit_overflow", overflow, 0);

      $display("[TB] FIFO overrun");
      start_job(32'h300);
      applyStimulus(4);
      for (int i = 0; i < 5; i++) begin
         miner_nonce_found = 1'b1;
         miner_nonce_out   = 32'h10 + i;
         applyStimulus(1);
      end
      miner_nonce_found = 1'b0;
      checkOutput("ovf_valid", result_valid, 1);
      checkOutput("ovf_head", result_nonce, 32'h10);
      checkOutput("ovf_flag", overflow, 1);
      applyStimulus(3);
      checkOutput("ovf_job_done", scan_done, 1);
      checkOutput("ovf_sticky", overflow, 1);
      start_job(32'h400);
      checkOutput("accept_clears_ovf", overflow, 0);
      checkOutput("accept_keeps_fifo", result_valid, 1);
      checkOutput("accept_keeps_head", result_nonce, 32'h10);
      checkOutput("job4_nonce_start", miner_nonce_start, 32'h400);

      $display("[TB] push and pop on a full FIFO at the last window cycle");
      applyStimulus(11);
      miner_nonce_found = 1'b1;
      miner_nonce_out   = 32'h20;
      result_ready      = 1'b1;
      applyStimulus(1);
      miner_nonce_found = 1'b0;
      checkOutput("fullpp_scan_done", scan_done, 1);
      checkOutput("fullpp_overflow", overflow, 0);
      checkOutput("fullpp_valid", result_valid, 1);
      checkOutput("fullpp_head0", result_nonce, 32'h11);
      applyStimulus(1);
      checkOutput("fullpp_head1", result_nonce, 32'h12);
      applyStimulus(1);
      checkOutput("fullpp_head2", result_nonce, 32'h13);
      applyStimulus(1);
      checkOutput("fullpp_head3", result_nonce, 32'h20);
      applyStimulus(1);
      checkOutput("fullpp_empty", result_valid, 0);
      result_ready = 1'b0;

      $display("[TB] abort in RUN with a hit on the abort cycle");
      start_job(32'h500);
      applyStimulus(6);
      abort             = 1'b1;
      miner_nonce_found = 1'b1;
      miner_nonce_out   = 32'h66;
      applyStimulus(1);
      abort             = 1'b0;
      miner_nonce_found = 1'b0;
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_work_ready", work_ready, 1);
      checkOutput("abort_miner_reset", miner_reset, 1);
      checkOutput("abort_scan_done", scan_done, 0);
      checkOutput("abort_hit_valid", result_valid, 1);
      checkOutput("abort_hit_nonce", result_nonce, 32'h66);
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1);
         checkOutput("abort_no_scan_done", scan_done, 0);
      end
      result_ready = 1'b1;
      applyStimulus(1);
      result_ready = 1'b0;
      checkOutput("abort_drain", result_valid, 0);

      $display("[TB] abort with work_valid in IDLE, then abort in LOAD");
      abort            = 1'b1;
      work_valid       = 1'b1;
      work_nonce_start = 32'h600;
      applyStimulus(1);
      work_valid = 1'b0;
      checkOutput("idle_abort_accept", busy, 1);
      checkOutput("idle_abort_nonce", miner_nonce_start, 32'h600);
      applyStimulus(1);
      abort = 1'b0;
      checkOutput("load_abort_busy", busy, 0);
      checkOutput("load_abort_ready", work_ready, 1);

      $display("[TB] reset during RUN with queued results");
      start_job(32'h700);
      applyStimulus(4);
      miner_nonce_found = 1'b1;
      miner_nonce_out   = 32'h70;
      applyStimulus(1);
      miner_nonce_out = 32'h71;
      applyStimulus(1);
      miner_nonce_found = 1'b0;
      checkOutput("prerst_valid", result_valid, 1);
      checkOutput("prerst_head", result_nonce, 32'h70);
      reset = 1'b1;
      applyStimulus(1);
      checkOutput("midrst_work_ready", work_ready, 1);
      checkOutput("midrst_miner_reset", miner_reset, 1);
      checkOutput("midrst_block_lo", miner_block[31:0], 0);
      checkOutput("midrst_block_hi", miner_block[639:608], 0);
      checkOutput("midrst_nonce_start", miner_nonce_start, 0);
      checkOutput("midrst_valid", result_valid, 0);
      checkOutput("midrst_nonce", result_nonce, 0);
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_scan_done", scan_done, 0);
      checkOutput("midrst_overflow", overflow, 0);
      reset            = 1'b0;
      work_valid       = 1'b1;
      work_nonce_start = 32'h800;
      applyStimulus(1);
      work_valid = 1'b0;
      checkOutput("postrst_accept", busy, 1);
      checkOutput("postrst_nonce", miner_nonce_start, 32'h800);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule
